ex_hazard_ctrl: RTL and testbench
=================================

# ex_hazard_ctrl

Hazard and forwarding controller for the RV32IC five-stage pipeline's EX-stage ALU. It tracks the destination registers of the instructions occupying EX and MEM, and detects read-after-write and load-use hazards for the instruction in ID. It then drives stall, bubble, flush and freeze controls to the pipeline registers, plus registered operand-forwarding selects for the ALU A/B inputs. It sits beside the ID/EX pipeline register and consumes the ALU's branch-taken result.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_id_valid  in  1  ID holds a real instruction.
- i_id_rs1, i_id_rs2  in  5 each  ID source registers.
- i_id_use_rs1, i_id_use_rs2  in  1 each  ID instruction reads that source.
- i_id_rd  in  5  ID destination register.
- i_id_regwrite  in  1  ID instruction writes rd.
- i_id_is_load  in  1  ID instruction is LB/LH/LW/LBU/LHU.
- i_ex_branch  in  1  ALU branch/jump taken this cycle (valid only when o_ex_valid=1).
- i_mem_busy  in  1  data memory not ready; whole pipe must hold.
- o_stall_if  out  1  hold PC.
- o_stall_id  out  1  hold IF/ID register.
- o_bubble_ex  out  1  load ID/EX with a bubble.
- o_flush_id  out  1  kill IF/ID contents (wrong path).
- o_freeze  out  1  hold every pipeline register.
- o_ex_valid  out  1  EX holds a real instruction.
- o_fwd_a, o_fwd_b  out  2 each  ALU operand select: 00 register file, 01 from MEM (ALUOutput), 10 from WB.
- o_stall_cycles  out  CNT_W  saturating count of load-use stall and freeze cycles.

## Operation
- Shadow registers: ex_{valid,rd,regwrite,is_load} and mem_{valid,rd,regwrite}.
- Advance (no freeze):
  - mem_* <= ex_*.
  - ex_* <= ID fields if ID moves, else bubble (valid=0).
- Hazard terms:
  - lu = i_id_valid & ex_valid & ex_is_load & ex_regwrite & ex_rd≠0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
  - br = o_ex_valid & i_ex_branch.
- Priority, highest first:
  1. i_mem_busy: o_freeze=1 and all other controls 0. Shadows, o_fwd_* and FSM data hold.
  2. br: o_flush_id=1, o_bubble_ex=1. ID instruction discarded. lu is ignored.
  3. lu: o_stall_if=o_stall_id=1, o_bubble_ex=1.
  4. Otherwise the ID instruction advances normally.
- Forwarding select, computed per source on ID advance:
  - 01 if ex_valid & ex_regwrite & ex_rd≠0 & rs==ex_rd.
  - Else 10 if the same test holds against mem_*.
  - Else 00.
  - Register x0 is never forwarded. The EX match beats the MEM match.
  - The result is registered into o_fwd_* as the instruction enters EX. A bubble entering EX loads 00.
- FSM states:
  - RUN: default.
  - LU_STALL: entered from RUN when lu is active and there is no br or busy. It lasts exactly one cycle, then returns to RUN. The consumer re-evaluates next cycle and gets fwd=10 from the load now in WB-bound MEM.
  - FREEZE: entered from any state while i_mem_busy=1. On deassert it returns to the state that was held.
  - A load-use stall interrupted by freeze resumes LU_STALL after the freeze.
- o_stall_cycles increments on every cycle with o_freeze=1 or lu stall active, and saturates at all-ones.
- o_ex_valid = ex_valid.

## Timing
- Reset (async, immediate):
  - state=RUN.
  - All shadows invalid, rd=0.
  - o_fwd_a=o_fwd_b=00; o_stall_cycles=0.
  - All stall/flush/bubble/freeze outputs 0.
- Stall, flush, bubble and freeze outputs are combinational from the current inputs and shadows, same cycle.
- o_fwd_* and shadows update on the rising i_clk edge. Forwarding has a latency of one cycle from ID to EX.
- Load-use penalty: exactly 1 bubble.
- Taken branch: 2 squashed slots. The ID instruction becomes a bubble and IF is flushed; the redirected fetch arrives next cycle.
- Simultaneous br and lu: flush only, no stall cycle, and the counter does not increment.
- Simultaneous busy and br: freeze. The branch is re-presented when busy drops, and the flush occurs then.
- Reset asserted mid-stall: outputs clear asynchronously. Operation resumes in RUN after the first edge following deassert.

## Test plan
- ADD x5 in EX, then ID `ADD x6,x5,x1` (use_rs1) -> no stall; after the edge o_fwd_a=01, o_fwd_b=00.
- LW x7 in EX, ID `ADDI x8,x7,4` -> one cycle with o_stall_if=o_stall_id=o_bubble_ex=1 and o_stall_cycles 0→1. Next cycle there is no stall, and after the edge o_fwd_a=10.
- Writes to x0 in EX and MEM, ID reads x0 -> o_fwd_a=o_fwd_b=00, no stall even if the EX write is a load.
- o_ex_valid=1, i_ex_branch=1 coincident with a load-use condition -> o_flush_id=1, o_bubble_ex=1, o_stall_if=0; after the edge ex_valid=0.
- i_mem_busy held 3 cycles during a load-use stall -> o_freeze=1 for 3 cycles, o_fwd_* unchanged, counter +3. Then 1 further stall cycle (counter +1), then normal advance.
- Counter preloaded near saturation via 65540 freeze cycles (CNT_W=16) -> o_stall_cycles=0xFFFF, holds. Async reset mid-freeze -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// Hazard and forwarding controller for the EX-stage ALU of a five-stage RV32IC pipeline.
// Tracks EX/MEM destinations, resolves load-use and taken-branch hazards, and registers ALU operand selects.
module ex_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_regwrite,
    input  logic             i_id_is_load,
    input  logic             i_ex_branch,
    input  logic             i_mem_busy,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_bubble_ex,
    output logic             o_flush_id,
    output logic             o_freeze,
    output logic             o_ex_valid,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } state_t;

    state_t state, state_next;
    state_t held, held_next;

    logic       ex_valid, ex_regwrite, ex_is_load;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_regwrite;
    logic [4:0] mem_rd;

    logic       lu, br, lu_stall, id_moves;
    logic [1:0] fwd_a_next, fwd_b_next;

    assign lu = i_id_valid && ex_valid && ex_is_load && ex_regwrite && (ex_rd != 5'd0) &&
                ((i_id_use_rs1 && (i_id_rs1 == ex_rd)) || (i_id_use_rs2 && (i_id_rs2 == ex_rd)));
    assign br       = ex_valid && i_ex_branch;
    assign lu_stall = lu && !br && !i_mem_busy;
    assign id_moves = i_id_valid && !br && !lu;

    assign o_ex_valid = ex_valid;

    // Controls are gated by reset so they drop immediately even while i_mem_busy is still high.
    always_comb begin
        o_stall_if  = 1'b0;
        o_stall_id  = 1'b0;
        o_bubble_ex = 1'b0;
        o_flush_id  = 1'b0;
        o_freeze    = 1'b0;
        if (!i_reset) begin
            if (i_mem_busy) begin
                o_freeze = 1'b1;
            end else if (br) begin
                o_flush_id  = 1'b1;
                o_bubble_ex = 1'b1;
            end else if (lu) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_bubble_ex = 1'b1;
            end
        end
    end

    // The producer in EX moves to MEM as the consumer enters EX, so an EX match becomes a MEM-forward.
    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (ex_valid && ex_regwrite && (ex_rd != 5'd0) && (i_id_rs1 == ex_rd)) begin
            fwd_a_next = 2'b01;
        end else if (mem_valid && mem_regwrite && (mem_rd != 5'd0) && (i_id_rs1 == mem_rd)) begin
            fwd_a_next = 2'b10;
        end
        if (ex_valid && ex_regwrite && (ex_rd != 5'd0) && (i_id_rs2 == ex_rd)) begin
            fwd_b_next = 2'b01;
        end else if (mem_valid && mem_regwrite && (mem_rd != 5'd0) && (i_id_rs2 == mem_rd)) begin
            fwd_b_next = 2'b10;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ex_valid     <= 1'b0;
            ex_rd        <= 5'd0;
            ex_regwrite  <= 1'b0;
            ex_is_load   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= 5'd0;
            mem_regwrite <= 1'b0;
            o_fwd_a      <= 2'b00;
            o_fwd_b      <= 2'b00;
        end else if (!i_mem_busy) begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            if (id_moves) begin
                ex_valid    <= 1'b1;
                ex_rd       <= i_id_rd;
                ex_regwrite <= i_id_regwrite;
                ex_is_load  <= i_id_is_load;
                o_fwd_a     <= fwd_a_next;
                o_fwd_b     <= fwd_b_next;
            end else begin
                ex_valid    <= 1'b0;
                ex_rd       <= 5'd0;
                ex_regwrite <= 1'b0;
                ex_is_load  <= 1'b0;
                o_fwd_a     <= 2'b00;
                o_fwd_b     <= 2'b00;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stall_cycles <= '0;
        end else if ((i_mem_busy || lu_stall) && (o_stall_cycles != {CNT_W{1'b1}})) begin
            o_stall_cycles <= o_stall_cycles + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= RUN;
            held  <= RUN;
        end else begin
            state <= state_next;
            held  <= held_next;
        end
    end

    // A freeze that lands on a pending load-use remembers it so the stall resumes afterwards.
    always_comb begin
        state_next = state;
        held_next  = held;
        case (state)
            RUN: begin
                if (i_mem_busy) begin
                    state_next = FREEZE;
                    held_next  = (lu && !br) ? LU_STALL : RUN;
                end else if (lu && !br) begin
                    state_next = LU_STALL;
                end
            end
            LU_STALL: begin
                if (i_mem_busy) begin
                    state_next = FREEZE;
                    held_next  = LU_STALL;
                end else begin
                    state_next = RUN;
                end
            end
            FREEZE: begin
                if (!i_mem_busy) begin
                    state_next = held;
                end
            end
            default: begin
                state_next = RUN;
                held_next  = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed-vector bench for ex_hazard_ctrl; a scoreboard queue holds hand-computed
// expectations that a free-running monitor compares on every falling clock edge.
module tb_ex_hazard_ctrl;

    typedef struct {
        logic       rst;
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
        logic       branch;
        logic       busy;
    } stim_t;

    typedef struct {
        string       name;
        logic        stall_if;
        logic        stall_id;
        logic        bubble;
        logic        flush;
        logic        freeze;
        logic        ex_valid;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
    logic        ex_branch, mem_busy;
    logic        stall_if, stall_id, bubble_ex, flush_id, freeze, ex_valid;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    exp_t expQ[$];

    ex_hazard_ctrl #(.CNT_W(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use_rs1   (id_use_rs1),
        .i_id_use_rs2   (id_use_rs2),
        .i_id_rd        (id_rd),
        .i_id_regwrite  (id_regwrite),
        .i_id_is_load   (id_is_load),
        .i_ex_branch    (ex_branch),
        .i_mem_busy     (mem_busy),
        .o_stall_if     (stall_if),
        .o_stall_id     (stall_id),
        .o_bubble_ex    (bubble_ex),
        .o_flush_id     (flush_id),
        .o_freeze       (freeze),
        .o_ex_valid     (ex_valid),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b),
        .o_stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic use1, input logic use2, input logic rw, input logic ld);
        stim_t s;
        s.rst = 1'b0; s.id_valid = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.use1 = use1; s.use2 = use2;
        s.rd = rd; s.regwrite = rw; s.is_load = ld; s.branch = 1'b0; s.busy = 1'b0;
        return s;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        s.id_valid = 1'b0;
        return s;
    endfunction

    function automatic exp_t mk(input string name, input logic sif, input logic sid, input logic bub,
                                input logic fl, input logic frz, input logic exv,
                                input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
        exp_t e;
        e.name = name; e.stall_if = sif; e.stall_id = sid; e.bubble = bub; e.flush = fl;
        e.freeze = frz; e.ex_valid = exv; e.fwd_a = fa; e.fwd_b = fb; e.cnt = cnt;
        return e;
    endfunction

    task automatic driveInputs(input stim_t s);
        reset       = s.rst;
        id_valid    = s.id_valid;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_use_rs1  = s.use1;
        id_use_rs2  = s.use2;
        id_rd       = s.rd;
        id_regwrite = s.regwrite;
        id_is_load  = s.is_load;
        ex_branch   = s.branch;
        mem_busy    = s.busy;
    endtask

    // One vector per clock: inputs change just after the rising edge, expectation is queued for the monitor.
    task automatic applyStimulus(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        driveInputs(s);
        expQ.push_back(e);
    endtask

    function automatic void cmp(input string nm, input string field, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
        end
    endfunction

    task automatic checkOutput(input exp_t e);
        cmp(e.name, "stall_if", 16'(stall_if), 16'(e.stall_if));
        cmp(e.name, "stall_id", 16'(stall_id), 16'(e.stall_id));
        cmp(e.name, "bubble_ex", 16'(bubble_ex), 16'(e.bubble));
        cmp(e.name, "flush_id", 16'(flush_id), 16'(e.flush));
        cmp(e.name, "freeze", 16'(freeze), 16'(e.freeze));
        cmp(e.name, "ex_valid", 16'(ex_valid), 16'(e.ex_valid));
        cmp(e.name, "fwd_a", 16'(fwd_a), 16'(e.fwd_a));
        cmp(e.name, "fwd_b", 16'(fwd_b), 16'(e.fwd_b));
        cmp(e.name, "stall_cycles", stall_cycles, e.cnt);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        driveInputs(s);

        applyStimulus(s, mk("reset", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd0));

        // Plain RAW: the ADD in EX forwards from MEM to the dependent ADD.
        applyStimulus(instr(5'd5, 5'd1, 5'd2, 1, 1, 1, 0), mk("add_x5", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd0));
        applyStimulus(instr(5'd6, 5'd5, 5'd1, 1, 0, 1, 0), mk("add_x6_id", 0,0,0,0,0, 1, 2'b00,2'b00, 16'd0));
        applyStimulus(idle(), mk("add_x6_ex", 0,0,0,0,0, 1, 2'b01,2'b00, 16'd0));
        applyStimulus(idle(), mk("drain1", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd0));

        // Load-use: one bubble, then WB forwarding.
        applyStimulus(instr(5'd7, 5'd2, 5'd0, 1, 0, 1, 1), mk("lw_x7", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd0));
        applyStimulus(instr(5'd8, 5'd7, 5'd0, 1, 0, 1, 0), mk("lu_stall", 1,1,1,0,0, 1, 2'b00,2'b00, 16'd0));
        applyStimulus(instr(5'd8, 5'd7, 5'd0, 1, 0, 1, 0), mk("lu_retry", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd1));
        applyStimulus(idle(), mk("addi_ex", 0,0,0,0,0, 1, 2'b10,2'b00, 16'd1));
        applyStimulus(idle(), mk("drain2", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd1));

        // x0 destinations never stall or forward, even for a load.
        applyStimulus(instr(5'd0, 5'd1, 5'd0, 1, 0, 1, 1), mk("lw_x0", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd1));
        applyStimulus(instr(5'd9, 5'd0, 5'd0, 1, 1, 1, 0), mk("rd_x0_vs_ex", 0,0,0,0,0, 1, 2'b00,2'b00, 16'd1));
        applyStimulus(instr(5'd10, 5'd0, 5'd0, 1, 1, 1, 0), mk("rd_x0_vs_mem", 0,0,0,0,0, 1, 2'b00,2'b00, 16'd1));
        applyStimulus(idle(), mk("x0_fwd_mem", 0,0,0,0,0, 1, 2'b00,2'b00, 16'd1));
        applyStimulus(idle(), mk("drain3", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd1));

        // Taken branch coinciding with load-use: flush only, no count.
        applyStimulus(instr(5'd11, 5'd1, 5'd0, 1, 0, 1, 1), mk("lw_x11", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd1));
        s = instr(5'd12, 5'd11, 5'd0, 1, 0, 1, 0);
        s.branch = 1'b1;
        applyStimulus(s, mk("br_and_lu", 0,0,1,1,0, 1, 2'b00,2'b00, 16'd1));
        applyStimulus(idle(), mk("after_br", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd1));

        // Freeze for three cycles over a pending load-use, with a live forward select.
        applyStimulus(instr(5'd14, 5'd1, 5'd2, 1, 1, 1, 0), mk("add_x14", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd1));
        applyStimulus(instr(5'd13, 5'd14, 5'd0, 1, 0, 1, 1), mk("lw_x13", 0,0,0,0,0, 1, 2'b00,2'b00, 16'd1));
        s = instr(5'd15, 5'd13, 5'd14, 1, 1, 1, 0);
        s.busy = 1'b1;
        applyStimulus(s, mk("freeze1", 0,0,0,0,1, 1, 2'b01,2'b00, 16'd1));
        applyStimulus(s, mk("freeze2", 0,0,0,0,1, 1, 2'b01,2'b00, 16'd2));
        applyStimulus(s, mk("freeze3", 0,0,0,0,1, 1, 2'b01,2'b00, 16'd3));
        s.busy = 1'b0;
        applyStimulus(s, mk("lu_after_freeze", 1,1,1,0,0, 1, 2'b01,2'b00, 16'd4));
        applyStimulus(s, mk("lu_resolved", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd5));
        applyStimulus(idle(), mk("add_x15_ex", 0,0,0,0,0, 1, 2'b10,2'b00, 16'd5));
        applyStimulus(idle(), mk("drain4", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd5));

        // Busy beats a taken branch; the flush happens once busy drops.
        applyStimulus(instr(5'd16, 5'd1, 5'd2, 1, 1, 1, 0), mk("add_x16", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd5));
        s = instr(5'd17, 5'd16, 5'd0, 1, 0, 1, 0);
        s.branch = 1'b1;
        s.busy   = 1'b1;
        applyStimulus(s, mk("busy_and_br", 0,0,0,0,1, 1, 2'b00,2'b00, 16'd5));
        s.busy = 1'b0;
        applyStimulus(s, mk("br_after_busy", 0,0,1,1,0, 1, 2'b00,2'b00, 16'd6));
        applyStimulus(idle(), mk("after_br2", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd6));

        // Long freeze drives the counter into saturation.
        s = idle();
        s.busy = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            #1;
            driveInputs(s);
        end
        applyStimulus(s, mk("saturated", 0,0,0,0,1, 0, 2'b00,2'b00, 16'hFFFF));
        applyStimulus(s, mk("sat_hold", 0,0,0,0,1, 0, 2'b00,2'b00, 16'hFFFF));
        s.rst = 1'b1;
        applyStimulus(s, mk("async_reset", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd0));

        applyStimulus(instr(5'd5, 5'd1, 5'd2, 1, 1, 1, 0), mk("post_reset", 0,0,0,0,0, 0, 2'b00,2'b00, 16'd0));
        applyStimulus(idle(), mk("post_reset_ex", 0,0,0,0,0, 1, 2'b00,2'b00, 16'd0));

        @(negedge clk);
        #1;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
